// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states,
// and the alignment rule used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      DATA,
      WR
`ifdef LSU_MISALIGN_CHECK_EN
      , ERR
`endif
   } lsu_state_e;

   // Size 2'b11 behaves as a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (size == SIZE_H) begin
         bad = addr_lo[0];
      end else if (size[1]) begin
         bad = (addr_lo != 2'b00);
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the word read back from memory.
module mem_lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel     = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_sel     = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
      load_data_o  = rdata_i;
      store_data_o = rdata_i;
      case (size_i)
         SIZE_B: begin
            load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            store_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_H: begin
            load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            store_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            load_data_o  = rdata_i;
            store_data_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide memory with 1-cycle read latency.
// Sub-word stores are read-modify-write. Optional macro: LSU_MISALIGN_CHECK_EN.
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_misaligned_o,
   output logic [31:0] mem_addr_r_o,
   input  logic [31:0] mem_data_r_i,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_w_o,
   output logic [31:0] mem_data_w_o
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] lane_load;
   logic [31:0] lane_store;
   logic        req_err;

   mem_lsu_lane u_lane (
      .size_i       (size_q),
      .unsigned_i   (uns_q),
      .addr_lo_i    (addr_q[1:0]),
      .rdata_i      (mem_data_r_i),
      .wdata_i      (wdata_q),
      .load_data_o  (lane_load),
      .store_data_o (lane_store)
   );

`ifdef LSU_MISALIGN_CHECK_EN
   assign req_err = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
   assign req_err = 1'b0;
`endif

   assign mem_addr_r_o = {addr_q[31:2], 2'b00};
   assign mem_addr_w_o = {addr_q[31:2], 2'b00};

   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      size_d           = size_q;
      uns_d            = uns_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      req_ready_o      = 1'b0;
      rsp_valid_o      = 1'b0;
      rsp_rdata_o      = '0;
      rsp_misaligned_o = 1'b0;
      mem_wr_en_o      = 1'b0;
      mem_data_w_o     = '0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
`ifdef LSU_MISALIGN_CHECK_EN
               if (req_err) begin
                  state_d = ERR;
               end else
`endif
               if (req_we_i && req_size_i[1]) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            state_d = DATA;
         end
         // Read data for the addressed word is valid here; stores merge and write back.
         DATA: begin
            rsp_valid_o = 1'b1;
            if (we_q) begin
               mem_wr_en_o  = 1'b1;
               mem_data_w_o = lane_store;
            end else begin
               rsp_rdata_o = lane_load;
            end
            state_d = IDLE;
         end
         WR: begin
            rsp_valid_o  = 1'b1;
            mem_wr_en_o  = 1'b1;
            mem_data_w_o = wdata_q;
            state_d      = IDLE;
         end
`ifdef LSU_MISALIGN_CHECK_EN
         ERR: begin
            rsp_valid_o      = 1'b1;
            rsp_misaligned_o = 1'b1;
            state_d          = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // req_err is only consumed when the alignment check is built in.
   logic unused_err;
   assign unused_err = req_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus random traffic compared
// cycle by cycle against a transaction-level model with its own memory image.
module tb_mem_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_uns = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_mis;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_data_r = '0;
   logic        mem_wr_en;
   logic [31:0] mem_addr_w;
   logic [31:0] mem_data_w;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_we_i         (req_we),
      .req_size_i       (req_size),
      .req_unsigned_i   (req_uns),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .rsp_valid_o      (rsp_valid),
      .rsp_rdata_o      (rsp_rdata),
      .rsp_misaligned_o (rsp_mis),
      .mem_addr_r_o     (mem_addr_r),
      .mem_data_r_i     (mem_data_r),
      .mem_wr_en_o      (mem_wr_en),
      .mem_addr_w_o     (mem_addr_w),
      .mem_data_w_o     (mem_data_w)
   );

   // Data memory seen by the DUT: registered read, whole-word write.
   logic [31:0] dmem [256];
   always @(posedge clk) begin
      mem_data_r <= dmem[mem_addr_r[9:2]];
      if (mem_wr_en) dmem[mem_addr_w[9:2]] <= mem_data_w;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] ref_mem [256];
   int          m_rem;
   logic        m_we, m_err, m_acc;
   logic [31:0] m_addr, m_load, m_store;

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lo);
      logic [31:0] v;
      if (size == SIZE_B) begin
         v = (word >> (8 * lo)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == SIZE_H) begin
         v = (word >> (16 * lo[1])) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      if (size == SIZE_B) begin
         mask = 32'hFF; sh = 8 * lo;
      end else if (size == SIZE_H) begin
         mask = 32'hFFFF; sh = 16 * lo[1];
      end else begin
         return wd;
      end
      return (word & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   function automatic logic model_misaligned(input logic [1:0] size, input logic [1:0] lo);
`ifdef LSU_MISALIGN_CHECK_EN
      if (size == SIZE_H) return lo[0];
      if (size >= SIZE_W) return lo != 0;
`endif
      return 1'b0;
   endfunction

   // m_rem counts cycles left in the current operation; the final cycle is the completion.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem = 0; m_we = 0; m_err = 0; m_acc = 0;
         m_addr = '0; m_load = '0; m_store = '0;
      end else begin
         m_acc = 0;
         if (m_rem > 0) begin
            if (m_rem == 1 && m_we && !m_err) ref_mem[m_addr[9:2]] = m_store;
            m_rem--;
         end else if (req_valid) begin
            m_acc   = 1;
            m_we    = req_we;
            m_addr  = req_addr;
            m_err   = model_misaligned(req_size, req_addr[1:0]);
            m_load  = model_load(ref_mem[req_addr[9:2]], req_size, req_uns, req_addr[1:0]);
            m_store = model_store(ref_mem[req_addr[9:2]], req_size, req_addr[1:0], req_wdata);
            m_rem   = (m_err || (req_we && req_size >= SIZE_W)) ? 1 : 2;
         end
      end
   end

   // Every cycle: compare all DUT outputs with what the model says they must be.
   always @(negedge clk) begin
      logic done;
      done = (m_rem == 1);
      chk("ready",      {31'b0, req_ready}, {31'b0, m_rem == 0});
      chk("rsp_valid",  {31'b0, rsp_valid}, {31'b0, done});
      chk("misaligned", {31'b0, rsp_mis},   {31'b0, done && m_err});
      chk("rdata",      rsp_rdata, (done && !m_we && !m_err) ? m_load : 32'h0);
      chk("wr_en",      {31'b0, mem_wr_en}, {31'b0, done && m_we && !m_err});
      chk("addr_r",     mem_addr_r, {m_addr[31:2], 2'b00});
      chk("addr_w",     mem_addr_w, {m_addr[31:2], 2'b00});
      if ((done && m_we && !m_err) || !rst_n)
         chk("data_w", mem_data_w, (done && m_we && !m_err) ? m_store : 32'h0);
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      bit ok;
      ok = 0;
      req_valid = 1; req_we = we; req_size = size; req_uns = uns;
      req_addr = addr; req_wdata = wd;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (m_acc) begin ok = 1; break; end
      end
      req_valid = 0;
      chk("accept_timeout", {31'b0, ok}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         dmem[i]    = ref_mem[i];
      end
      ref_mem[8'h10] = 32'h8899_AABB; dmem[8'h10] = 32'h8899_AABB;
      ref_mem[8'h20] = 32'h1234_5678; dmem[8'h20] = 32'h1234_5678;

      #3;
      chk("rst_ready",  {31'b0, req_ready}, 32'd1);
      chk("rst_valid",  {31'b0, rsp_valid}, 32'd0);
      chk("rst_addr_r", mem_addr_r, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      issue(0, SIZE_B, 0, 32'h41, 32'h0);
      @(negedge clk); chk("ldb_early", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk); chk("ldb_valid", {31'b0, rsp_valid}, 32'd1);
      chk("ldb_data", rsp_rdata, 32'hFFFF_FFAA);

      issue(0, SIZE_H, 1, 32'h42, 32'h0);
      repeat (2) @(negedge clk);
      chk("ldh_data", rsp_rdata, 32'h0000_8899);

      issue(0, SIZE_W, 0, 32'h40, 32'h0);
      repeat (2) @(negedge clk);
      chk("ldw_data", rsp_rdata, 32'h8899_AABB);

      issue(1, SIZE_B, 0, 32'h43, 32'h0000_0011);
      @(negedge clk); chk("stb_no_early_wr", {31'b0, mem_wr_en}, 32'd0);
      @(negedge clk); chk("stb_wr", {31'b0, mem_wr_en}, 32'd1);
      chk("stb_data", mem_data_w, 32'h1199_AABB);
      chk("stb_addr", mem_addr_w, 32'h40);
      chk("stb_rdata0", rsp_rdata, 32'h0);
      issue(0, SIZE_W, 0, 32'h40, 32'h0);
      repeat (2) @(negedge clk);
      chk("stb_readback", rsp_rdata, 32'h1199_AABB);

      issue(1, SIZE_W, 0, 32'h44, 32'hDEAD_BEEF);
      @(negedge clk); chk("stw_wr", {31'b0, mem_wr_en}, 32'd1);
      chk("stw_data", mem_data_w, 32'hDEAD_BEEF);
      @(negedge clk); chk("stw_one_pulse", {31'b0, mem_wr_en}, 32'd0);

      issue(0, SIZE_W, 0, 32'h46, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      @(negedge clk);
      chk("mis_flag", {31'b0, rsp_mis}, 32'd1);
      chk("mis_no_wr", {31'b0, mem_wr_en}, 32'd0);
`else
      repeat (2) @(negedge clk);
      chk("unaligned_word", rsp_rdata, 32'hDEAD_BEEF);
`endif

      // Abort a byte store in its write cycle with reset.
      repeat (2) @(negedge clk);
      issue(1, SIZE_B, 0, 32'h81, 32'h55);
      @(posedge clk); #1;
      chk("abort_pre_wr", {31'b0, mem_wr_en}, 32'd1);
      rst_n = 0; #1;
      chk("abort_wr", {31'b0, mem_wr_en}, 32'd0);
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      issue(0, SIZE_W, 0, 32'h80, 32'h0);
      repeat (2) @(negedge clk);
      chk("abort_mem_kept", rsp_rdata, 32'h1234_5678);

      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = $urandom_range(0, 1);
         req_size  = $urandom_range(0, 3);
         req_uns   = $urandom_range(0, 1);
         req_addr  = $urandom_range(0, 1023);
         req_wdata = $urandom;
      end
      req_valid = 0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 256; i++)
         if (dmem[i] !== ref_mem[i]) chk("final_mem", dmem[i], ref_mem[i]);
      chk("final_mem_word", dmem[8'h11], ref_mem[8'h11]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port req_valid_i, input, 1 bit: core request valid.
REQ-004 SHALL have port req_ready_o, output, 1 bit: request accepted when valid and ready are both high at a clock edge.
REQ-005 SHALL have port req_we_i, input, 1 bit: 1 means store, 0 means load.
REQ-006 SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have port req_unsigned_i, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have ports req_addr_i and req_wdata_i, inputs, 32 bits each: byte address and store data (right-aligned).
REQ-009 SHALL have ports rsp_valid_o (1), rsp_rdata_o (32) and rsp_misaligned_o (1), outputs: one-cycle completion pulse, load result, and error flag.
REQ-010 SHALL have ports mem_addr_r_o (32, output), mem_data_r_i (32, input), mem_wr_en_o (1, output), mem_addr_w_o (32, output) and mem_data_w_o (32, output), driving the word-wide data memory. The memory has 1-cycle registered read data and no byte enables.

Function
REQ-011 SHALL implement FSM states IDLE, RD, DATA, WR and ERR.
REQ-012 In IDLE: req_ready_o=1; in all other states req_ready_o=0.
REQ-013 On accept, SHALL latch we, size, unsigned, addr and wdata, and go to:
- ERR if misaligned (REQ-025);
- WR if store word;
- RD otherwise.
REQ-014 SHALL drive mem_addr_r_o and mem_addr_w_o as {latched_addr[31:2],2'b00} in every state.
REQ-015 RD: drives the read address only, then goes to DATA.
REQ-016 DATA, load: rsp_valid_o=1, rsp_rdata_o = selected lane (byte by addr[1:0], half by addr[1]), sign- or zero-extended; then IDLE.
REQ-017 DATA, byte/half store: mem_wr_en_o=1, mem_data_w_o = mem_data_r_i with the addressed lane replaced by low wdata bits, rsp_valid_o=1; then IDLE.
REQ-018 WR: mem_wr_en_o=1, mem_data_w_o = latched wdata, rsp_valid_o=1; then IDLE.
REQ-019 ERR: rsp_valid_o=1, rsp_misaligned_o=1, no memory write; then IDLE.
REQ-020 Latency from the accept edge: load response 2 cycles, byte/half store write and response 2 cycles, word store 1 cycle, error 1 cycle.
REQ-021 rsp_rdata_o SHALL be 0 whenever rsp_valid_o=0 or the completion is a store.
REQ-022 mem_wr_en_o SHALL be high only in WR or store-DATA, for exactly one cycle per store.
REQ-023 The response has no back-pressure; the next request is accepted no earlier than the cycle after rsp_valid_o.

Reset
REQ-024 While rst_ni=0: state=IDLE, latched registers=0, req_ready_o=1, rsp_valid_o=0, rsp_misaligned_o=0, mem_wr_en_o=0, and all data/address outputs=0. Reset during RD or DATA SHALL abort the operation with no write.

Configuration
REQ-025 With macro LSU_MISALIGN_CHECK_EN defined, a request is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]!=0; such requests take the ERR path.
REQ-026 Without LSU_MISALIGN_CHECK_EN: the ERR state is absent, rsp_misaligned_o is tied 0, a half uses addr[1] only, and a word ignores addr[1:0].

Structure
REQ-027 The shared package lsu_pkg SHALL hold the size encoding (SIZE_B, SIZE_H, SIZE_W) and the FSM state enum.
REQ-028 Sub-module mem_lsu_lane (combinational) SHALL implement load extract/extend and store merge, instantiated once.

Verification
REQ-029 Preload word 0x40 with 0x8899AABB; load byte signed at 0x41 -> rsp at accept+2 with rdata 0xFFFFFFAA.
REQ-030 Same word; load half unsigned at 0x42 -> rdata 0x00008899; load word at 0x40 -> 0x8899AABB.
REQ-031 Store byte 0x11 at 0x43 -> single write at accept+2, data 0x1199AABB to address 0x40; readback matches.
REQ-032 Store word 0xDEADBEEF at 0x44 -> write at accept+1; mem_wr_en_o high exactly one cycle.
REQ-033 Load word at 0x46 -> with LSU_MISALIGN_CHECK_EN: rsp_misaligned_o=1 at accept+1 and no memory write; without it: rdata equals the word at 0x44.
REQ-034 Assert rst_ni low in the DATA state of a byte store -> no mem_wr_en_o pulse and req_ready_o=1.
